// File: rtl/register_ram_pkg.sv
// Shared types and helpers for the dual-read register RAM: state encoding,
// size helpers and the byte-lane merge used on every write.
package register_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MAX_WIDTH = 256;
  localparam int IDX_W     = $clog2(MAX_WIDTH);

  typedef logic [MAX_WIDTH-1:0] word_t;

  function automatic int calc_lanes(input int data_width, input int byte_width);
    return data_width / byte_width;
  endfunction

  function automatic int calc_depth(input int addr_width);
    return 2 ** addr_width;
  endfunction

  // Bit i comes from new_word when the lane that owns it is enabled.
  function automatic word_t merge(input word_t old_word, input word_t new_word,
                                  input word_t lane_enable, input int byte_width);
    word_t result;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      result[IDX_W'(i)] = lane_enable[IDX_W'(i / byte_width)] ? new_word[IDX_W'(i)]
                                                               : old_word[IDX_W'(i)];
    end
    return result;
  endfunction

endpackage

// File: rtl/register_ram_bank.sv
// One-write/one-read array with byte-enable write and registered read address.
// Reading through the registered address returns the word as updated on that edge.
module register_ram_bank
  import register_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                             clock,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]            data_input,
  input  logic [ADDR_WIDTH-1:0]            read_address,
  output logic [DATA_WIDTH-1:0]            read_data
);

  localparam int DEPTH = calc_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] read_address_q;

  always_ff @(posedge clock) begin
    if (write_enable) begin
      mem[write_address] <= DATA_WIDTH'(merge(word_t'(mem[write_address]), word_t'(data_input),
                                              word_t'(byte_enable), BYTE_WIDTH));
    end
    read_address_q <= read_address;
  end

  assign read_data = mem[read_address_q];

endmodule

// File: rtl/register_ram_mp.sv
// Register-set memory with one byte-enabled write port, two latency-1 read ports
// with hold-on-disable, and a clear sequencer that zero-fills the array after reset.
module register_ram_mp
  import register_ram_pkg::*;
#(
  parameter int                          DATA_WIDTH     = 32,
  parameter int                          BYTE_WIDTH     = 8,
  parameter int                          ADDR_WIDTH     = 3,
  parameter int                          CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0]       CLEAR_VALUE    = '0
) (
  input  logic                             clock,
  input  logic                             reset,
  output logic                             ready,
  input  logic                             write_enable,
  input  logic [ADDR_WIDTH-1:0]            write_address,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]            data_input,
  input  logic                             read_enable_a,
  input  logic [ADDR_WIDTH-1:0]            read_address_a,
  output logic [DATA_WIDTH-1:0]            read_data_a,
  input  logic                             read_enable_b,
  input  logic [ADDR_WIDTH-1:0]            read_address_b,
  output logic [DATA_WIDTH-1:0]            read_data_b,
  output state_t                           debug_state
);

  localparam int LANES = calc_lanes(DATA_WIDTH, BYTE_WIDTH);
  localparam int DEPTH = calc_depth(ADDR_WIDTH);

  // ready is a level status, not a per-transfer handshake: while it is low every
  // write and read request is discarded; while high each request is accepted on
  // the edge it is presented, with no back-pressure.
  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  bank_we;
  logic [ADDR_WIDTH-1:0] bank_addr;
  logic [LANES-1:0]      bank_be;
  logic [DATA_WIDTH-1:0] bank_din;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    bank_we   = 1'b0;
    bank_addr = write_address;
    bank_be   = byte_enable;
    bank_din  = data_input;
    case (state_q)
      CLEAR: begin
        if (CLEAR_ON_RESET != 0) begin
          bank_we   = 1'b1;
          bank_addr = count_q[ADDR_WIDTH-1:0];
          bank_be   = '1;
          bank_din  = CLEAR_VALUE;
          count_d   = count_q + 1'b1;
          if (count_q == (ADDR_WIDTH+1)'(DEPTH - 1)) state_d = READY;
        end else begin
          state_d = READY;
        end
      end
      READY: bank_we = write_enable;
    endcase
    if (reset) bank_we = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CLEAR;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign ready       = (state_q == READY);
  assign debug_state = state_q;

  logic                  rd_en   [2];
  logic [ADDR_WIDTH-1:0] rd_addr [2];
  logic [DATA_WIDTH-1:0] rd_data [2];

  assign rd_en[0]   = read_enable_a;
  assign rd_en[1]   = read_enable_b;
  assign rd_addr[0] = read_address_a;
  assign rd_addr[1] = read_address_b;

  // Same-edge forwarding comes from the bank: its array updates and its read
  // address registers on the capture edge, so the output shows the merged word.
  // fresh_q marks the cycle right after a capture; afterwards hold_q freezes
  // the word so later writes to that entry do not leak into a disabled port.
  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_WIDTH-1:0] bank_data;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  fresh_q;

    register_ram_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .BYTE_WIDTH(BYTE_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .clock        (clock),
      .write_enable (bank_we),
      .write_address(bank_addr),
      .byte_enable  (bank_be),
      .data_input   (bank_din),
      .read_address (rd_addr[p]),
      .read_data    (bank_data)
    );

    always_ff @(posedge clock) begin
      if (reset || state_q != READY) begin
        fresh_q <= 1'b0;
        hold_q  <= '0;
      end else begin
        if (fresh_q) hold_q <= bank_data;
        fresh_q <= rd_en[p];
      end
    end

    assign rd_data[p] = fresh_q ? bank_data : hold_q;
  end

  assign read_data_a = rd_data[0];
  assign read_data_b = rd_data[1];

endmodule

// File: tb/tb_register_ram_mp.sv
// Directed and random checks of register_ram_mp: clear sequencing, byte-lane
// writes, dual-port forwarding, read hold, mid-clear reset and the no-clear build.
module tb_register_ram_mp;
  import register_ram_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ready;
  logic        write_enable = 1'b0;
  logic [2:0]  write_address = '0;
  logic [3:0]  byte_enable = '0;
  logic [31:0] data_input = '0;
  logic        read_enable_a = 1'b0;
  logic [2:0]  read_address_a = '0;
  logic [31:0] read_data_a;
  logic        read_enable_b = 1'b0;
  logic [2:0]  read_address_b = '0;
  logic [31:0] read_data_b;
  state_t      debug_state;

  logic        reset2 = 1'b1;
  logic        ready2;
  logic        write_enable2 = 1'b0;
  logic [2:0]  write_address2 = '0;
  logic [3:0]  byte_enable2 = '0;
  logic [31:0] data_input2 = '0;
  logic        read_enable_a2 = 1'b0;
  logic [2:0]  read_address_a2 = '0;
  logic [31:0] read_data_a2;
  logic        read_enable_b2 = 1'b0;
  logic [2:0]  read_address_b2 = '0;
  logic [31:0] read_data_b2;
  state_t      debug_state2;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  logic [31:0] model [8];
  logic [31:0] exp_hold_a = '0;
  logic [31:0] exp_hold_b = '0;

  register_ram_mp dut (
    .clock(clock), .reset(reset), .ready(ready),
    .write_enable(write_enable), .write_address(write_address),
    .byte_enable(byte_enable), .data_input(data_input),
    .read_enable_a(read_enable_a), .read_address_a(read_address_a), .read_data_a(read_data_a),
    .read_enable_b(read_enable_b), .read_address_b(read_address_b), .read_data_b(read_data_b),
    .debug_state(debug_state)
  );

  register_ram_mp #(.CLEAR_ON_RESET(0)) dut_nc (
    .clock(clock), .reset(reset2), .ready(ready2),
    .write_enable(write_enable2), .write_address(write_address2),
    .byte_enable(byte_enable2), .data_input(data_input2),
    .read_enable_a(read_enable_a2), .read_address_a(read_address_a2), .read_data_a(read_data_a2),
    .read_enable_b(read_enable_b2), .read_address_b(read_address_b2), .read_data_b(read_data_b2),
    .debug_state(debug_state2)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int l = 0; l < 4; l++) if (be[l]) r[l*8 +: 8] = new_w[l*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] expect_read(input logic [2:0] addr, input logic we,
                                              input logic [2:0] wa, input logic [3:0] be,
                                              input logic [31:0] din);
    if (we && wa == addr) return lane_merge(model[addr], din, be);
    return model[addr];
  endfunction

  // one READY-state cycle: predict both ports, drive, advance, score
  task automatic cycle(input string tag, input logic we, input logic [2:0] wa, input logic [3:0] be,
                       input logic [31:0] din, input logic ea, input logic [2:0] aa,
                       input logic eb, input logic [2:0] ab);
    logic [31:0] va, vb, pa, pb;
    va = ea ? expect_read(aa, we, wa, be, din) : exp_hold_a;
    vb = eb ? expect_read(ab, we, wa, be, din) : exp_hold_b;
    exp_q.push_back(va);
    exp_q.push_back(vb);
    exp_hold_a = va;
    exp_hold_b = vb;
    write_enable = we; write_address = wa; byte_enable = be; data_input = din;
    read_enable_a = ea; read_address_a = aa; read_enable_b = eb; read_address_b = ab;
    step();
    if (we) model[wa] = lane_merge(model[wa], din, be);
    write_enable = 1'b0; read_enable_a = 1'b0; read_enable_b = 1'b0;
    if (exp_q.size() < 2) begin
      check({tag, "_queue"}, 32'(exp_q.size()), 32'd2);
    end else begin
      pa = exp_q.pop_front();
      pb = exp_q.pop_front();
      check({tag, "_a"}, read_data_a, pa);
      check({tag, "_b"}, read_data_b, pb);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) model[i] = '0;

    // power-on reset and clear sequence
    step();
    step();
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_rd_a", read_data_a, 32'h0);
    check("reset_rd_b", read_data_b, 32'h0);
    check("reset_state", 32'(debug_state), 32'(CLEAR));
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("clear_ready_e%0d", e), 32'(ready), (e == 8) ? 32'd1 : 32'd0);
    end
    check("ready_state", 32'(debug_state), 32'(READY));

    for (int i = 0; i < 8; i++)
      cycle($sformatf("zero_%0d", i), 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'(i), 1'b1, 3'(7 - i));

    // byte-lane partial write
    cycle("wr3_full", 1'b1, 3'd3, 4'b1111, 32'hDEADBEEF, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("wr3_part", 1'b1, 3'd3, 4'b0101, 32'h11223344, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("rd3", 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd3, 1'b0, 3'd0);
    check("rd3_literal", read_data_a, 32'hDE22BE44);

    // both ports forward a partial write on the same edge
    cycle("wr5_full", 1'b1, 3'd5, 4'b1111, 32'h12345678, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("fwd5", 1'b1, 3'd5, 4'b1100, 32'hCAFEF00D, 1'b1, 3'd5, 1'b1, 3'd5);
    check("fwd5_a_literal", read_data_a, 32'hCAFE5678);
    check("fwd5_b_literal", read_data_b, 32'hCAFE5678);

    // port A holds while disabled, even when its entry is rewritten
    cycle("wr2", 1'b1, 3'd2, 4'b1111, 32'h22222222, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("wr6", 1'b1, 3'd6, 4'b1111, 32'h66666666, 1'b0, 3'd0, 1'b0, 3'd0);
    cycle("rd2", 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd2, 1'b1, 3'd2);
    cycle("hold_a", 1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd6, 1'b1, 3'd6);
    check("hold_a_literal", read_data_a, 32'h22222222);
    check("upd_b_literal", read_data_b, 32'h66666666);
    cycle("hold_a_wr", 1'b1, 3'd2, 4'b1111, 32'h99999999, 1'b0, 3'd6, 1'b0, 3'd6);
    check("hold_a_wr_literal", read_data_a, 32'h22222222);

    // byte_enable zero is a no-op write
    cycle("be0", 1'b1, 3'd6, 4'b0000, 32'hFFFFFFFF, 1'b1, 3'd6, 1'b0, 3'd0);
    check("be0_literal", read_data_a, 32'h66666666);

    // random traffic
    for (int n = 0; n < 24; n++)
      cycle($sformatf("rand_%0d", n), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            4'($urandom_range(0, 15)), $urandom(), 1'($urandom_range(0, 1)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));

    // reset with a write on the same edge, then interrupt the clear after 4 cycles
    reset = 1'b1;
    write_enable = 1'b1; write_address = 3'd4; byte_enable = 4'hF; data_input = 32'hFFFFFFFF;
    step();
    reset = 1'b0;
    read_enable_a = 1'b1; read_enable_b = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      read_address_a = 3'(e); read_address_b = 3'(7 - e);
      step();
      check($sformatf("part_clear_ready_%0d", e), 32'(ready), 32'd0);
      check($sformatf("part_clear_rd_a_%0d", e), read_data_a, 32'h0);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      write_address = 3'(e % 8); data_input = 32'hA0A0A0A0 ^ 32'(e);
      step();
      check($sformatf("reclear_ready_e%0d", e), 32'(ready), (e == 8) ? 32'd1 : 32'd0);
      if (e < 8) check($sformatf("reclear_rd_b_e%0d", e), read_data_b, 32'h0);
    end
    write_enable = 1'b0; read_enable_a = 1'b0; read_enable_b = 1'b0;
    for (int i = 0; i < 8; i++) model[i] = '0;
    exp_hold_a = '0;
    exp_hold_b = '0;
    for (int i = 0; i < 8; i++)
      cycle($sformatf("reclear_zero_%0d", i), 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'(i), 1'b1, 3'(i));

    // build without clear: ready one edge after release
    check("nc_reset_ready", 32'(ready2), 32'd0);
    reset2 = 1'b0;
    check("nc_prerelease_ready", 32'(ready2), 32'd0);
    step();
    check("nc_ready", 32'(ready2), 32'd1);
    write_enable2 = 1'b1; write_address2 = 3'd7; byte_enable2 = 4'hF; data_input2 = 32'hA5A5A5A5;
    step();
    write_enable2 = 1'b0;
    read_enable_a2 = 1'b1; read_address_a2 = 3'd7;
    exp_q.push_back(32'hA5A5A5A5);
    step();
    read_enable_a2 = 1'b0;
    if (exp_q.size() > 0) check("nc_rd7", read_data_a2, exp_q.pop_front());
    write_enable2 = 1'b1; byte_enable2 = 4'b0011; data_input2 = 32'h00005A5A;
    read_enable_b2 = 1'b1; read_address_b2 = 3'd7;
    exp_q.push_back(32'hA5A55A5A);
    step();
    write_enable2 = 1'b0; read_enable_b2 = 1'b0;
    if (exp_q.size() > 0) check("nc_fwd7", read_data_b2, exp_q.pop_front());
    check("nc_hold_a", read_data_a2, 32'hA5A5A5A5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_ram_mp.md
Name: register_ram_mp

Overview:
- Parametrised register-set memory: one write port with byte enables, two independent synchronous read ports.
- Successor to the single-port register set. It adds configurable width and depth, two read ports, write-to-read forwarding, per-port read enable and a hardware clear-after-reset sequencer.
- Sits between the core's register-access logic and the RAM fabric. Lets source and destination operands be fetched in the same cycle.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per byte-enable lane.
- ADDR_WIDTH, 3, address bits; depth = 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = zero-fill every entry after reset; 0 = skip.
- CLEAR_VALUE, 0, word written to each entry during clear (DATA_WIDTH bits).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- ready  out  1  high when the array accepts writes and reads return array data.
- write_enable  in  1  write strobe.
- write_address  in  ADDR_WIDTH  write entry.
- byte_enable  in  DATA_WIDTH/BYTE_WIDTH  lane i writes data_input bits [i*BYTE_WIDTH +: BYTE_WIDTH].
- data_input  in  DATA_WIDTH  write data.
- read_enable_a  in  1  port A capture enable.
- read_address_a  in  ADDR_WIDTH  port A address.
- read_data_a  out  DATA_WIDTH  port A data.
- read_enable_b  in  1  port B capture enable.
- read_address_b  in  ADDR_WIDTH  port B address.
- read_data_b  out  DATA_WIDTH  port B data.

Behaviour:
- Reset values: ready=0, read_data_a=0, read_data_b=0, state=CLEAR (or READY-pending when CLEAR_ON_RESET=0), clear counter=0.
- State CLEAR:
  - Each cycle writes CLEAR_VALUE with all lanes enabled to entry clear_counter, then increments the counter.
  - At the edge writing entry depth-1, moves to READY; ready=1 from that edge.
  - Depth 8 means ready rises on the 8th edge after the first edge with reset low.
  - External writes are ignored. read_data_a and read_data_b are held at 0.
- CLEAR_ON_RESET=0: moves to READY at the first edge with reset low. Array contents are undefined until written.
- State READY:
  - Write: on an edge with write_enable=1, only enabled lanes of write_address are updated; other lanes keep their value.
  - byte_enable=0 with write_enable=1 is a legal no-op.
- Read, latency 1: on an edge with read_enable_x=1, read_data_x takes the word at read_address_x. With read_enable_x=0, read_data_x holds its previous value.
- Forwarding: if the same edge writes read_address_x:
  - enabled lanes of read_data_x take data_input;
  - disabled lanes take the old stored value.
  - No stale data is ever returned. This applies to both ports independently, including both ports reading the written address.
- Reset mid-operation:
  - Reset in any state (including mid-clear) returns to CLEAR with counter=0 and restarts the full sequence.
  - A write presented on the same edge as reset is dropped.
- Counter: ADDR_WIDTH+1 bits wide, so depth-1 is detected without wrap ambiguity. The counter never wraps inside READY.

Decomposition:
- Package register_ram_pkg:
  - state encoding (CLEAR, READY);
  - derived constants LANES = DATA_WIDTH/BYTE_WIDTH and DEPTH = 2**ADDR_WIDTH;
  - lane-merge function merge(old, new, byte_enable).
- Sub-module register_ram_bank: inferred one-write/one-read array with byte-enable write and registered read address.
  - Instantiated twice, one per read port; both banks receive identical write traffic, so contents stay coherent.
  - Forwarding, read enables, output hold and the clear FSM stay in register_ram_mp.

Test Plan:
- Reset 2 cycles, release -> ready low for exactly 8 edges, then high; reads of entries 0..7 return 0x00000000.
- Write 0xDEADBEEF to entry 3 with byte_enable=4'b1111, then byte_enable=4'b0101 with data 0x11223344 -> read entry 3 returns 0xDE22BE44.
- Port A reads 5 and port B reads 5 on the same edge as writing 0xCAFEF00D with byte_enable=4'b1100 over stored 0x12345678 -> both ports return 0xCAFE5678 next cycle.
- read_enable_a=0 while port A address changes 2->6 -> read_data_a holds the previous word; port B updates normally.
- Assert reset for 1 cycle after 4 clear cycles -> ready stays low a further 8 edges; writes attempted during clear leave entries reading 0.
- CLEAR_ON_RESET=0 build -> ready=1 one edge after reset release; write 0xA5A5A5A5 to entry 7 and read it back with latency 1.
